// File: rtl/munoc_rr_merge_arbiter.sv
// munoc_rr_merge_arbiter
// Packet-aware round-robin merger: drains NUM_INPUT lane buffers into one
// downstream stream. A grant is held from the first beat of a packet until
// its last beat. ORDERED=1 waits on the pointer lane so that a stream dealt
// round-robin across the lanes comes back out in its original order.
// ORDERED=0 skips idle lanes (work-conserving), searching upward from the
// pointer with wrap-around.
module munoc_rr_merge_arbiter #(
    parameter int NUM_INPUT = 2,
    parameter int BW_DATA   = 32,
    parameter int ORDERED   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init,
    input  logic [NUM_INPUT-1:0]           in_rready,
    output logic [NUM_INPUT-1:0]           in_rrequest,
    input  logic [NUM_INPUT*BW_DATA-1:0]   in_rdata,
    input  logic [NUM_INPUT-1:0]           in_rlast,
    input  logic                           out_wready,
    output logic                           out_wrequest,
    output logic [BW_DATA-1:0]             out_wdata,
    output logic                           out_wlast,
    output logic [NUM_INPUT-1:0]           grant_onehot,
    output logic                           busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Pointer starts on lane 0 after reset or init.
    localparam logic [NUM_INPUT-1:0] PTR_INIT = NUM_INPUT'(1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [NUM_INPUT-1:0]   ptr_reg;
    logic [NUM_INPUT-1:0]   ptr_next;
    logic [NUM_INPUT-1:0]   lock_sel_reg;
    logic [NUM_INPUT-1:0]   lock_sel_next;

    logic [NUM_INPUT-1:0]   search_sel;
    logic                   search_found;
    logic [NUM_INPUT-1:0]   sel;
    logic                   sel_last;
    logic                   xfer;
    logic [BW_DATA-1:0]     lane_masked [NUM_INPUT];
    logic [BW_DATA-1:0]     mux_data;

    // One-hot rotate-left with wrap; for a single lane this is the identity,
    // which keeps the pointer constant.
    function automatic logic [NUM_INPUT-1:0] rotl(input logic [NUM_INPUT-1:0] v);
        logic [NUM_INPUT-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            r[(i + 1) % NUM_INPUT] = v[i];
        end
        return r;
    endfunction

    // Work-conserving search: first ready lane at or above the pointer,
    // wrapping around. The lane that just finished sits right below the
    // pointer, so it is examined last.
    always_comb begin
        search_sel   = '0;
        search_found = 1'b0;
        for (int j = 0; j < NUM_INPUT; j++) begin
            for (int k = 0; k < NUM_INPUT; k++) begin
                if (!search_found && ptr_reg[j] && in_rready[(j + k) % NUM_INPUT]) begin
                    search_sel[(j + k) % NUM_INPUT] = 1'b1;
                    search_found                    = 1'b1;
                end
            end
        end
    end

    // Lane selection: locked lane wins outright; otherwise the pointer lane
    // (ordered) or the search result (work-conserving).
    always_comb begin
        sel = '0;
        if (state_reg == ST_LOCKED) begin
            sel = lock_sel_reg;
        end else if (ORDERED != 0) begin
            sel = ptr_reg & in_rready;
        end else begin
            sel = search_sel;
        end
    end

    // Per-lane AND mask so the data mux is a plain OR reduction.
    for (genvar gi = 0; gi < NUM_INPUT; gi++) begin : g_lane_mask
        assign lane_masked[gi] = in_rdata[BW_DATA*gi +: BW_DATA] & {BW_DATA{sel[gi]}};
    end

    // OR-reduce the masked lanes into the selected beat.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            mux_data = mux_data | lane_masked[i];
        end
    end

    assign sel_last = |(sel & in_rlast);
    assign xfer     = (|(sel & in_rready)) & out_wready & ~init & ~rst;

    assign out_wrequest = xfer;
    assign in_rrequest  = xfer ? (sel & in_rready) : '0;
    assign out_wdata    = rst ? '0 : mux_data;
    assign out_wlast    = sel_last & ~rst;
    assign grant_onehot = sel & {NUM_INPUT{~rst}};
    assign busy         = (state_reg == ST_LOCKED) & ~rst;

    // Next-state: init abandons any packet in flight; otherwise only a
    // transferred beat moves the FSM, pointer or lock.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        lock_sel_next = lock_sel_reg;
        if (init) begin
            state_next    = ST_IDLE;
            ptr_next      = PTR_INIT;
            lock_sel_next = '0;
        end else if (xfer) begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_last) begin
                        ptr_next = rotl(sel);
                    end else begin
                        state_next    = ST_LOCKED;
                        lock_sel_next = sel;
                    end
                end
                ST_LOCKED: begin
                    if (sel_last) begin
                        state_next    = ST_IDLE;
                        ptr_next      = rotl(lock_sel_reg);
                        lock_sel_next = '0;
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    ptr_next      = PTR_INIT;
                    lock_sel_next = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= PTR_INIT;
            lock_sel_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            lock_sel_reg <= lock_sel_next;
        end
    end

endmodule

// File: tb/tb_munoc_rr_merge_arbiter.sv
// Bench for munoc_rr_merge_arbiter: one work-conserving and one ordered
// instance share the lane stimulus; expected beats are queued as they are
// offered and checked by a negedge monitor when the DUT moves them.
module tb_munoc_rr_merge_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          init;
    logic          out_wready;
    logic [N-1:0]  in_rready;
    logic [N-1:0]  in_rlast;
    logic [W-1:0]  lane_data [N];
    logic [N*W-1:0] in_rdata;

    logic [N-1:0]  in_rrequest_a, grant_onehot_a;
    logic          out_wrequest_a, out_wlast_a, busy_a;
    logic [W-1:0]  out_wdata_a;
    logic [N-1:0]  in_rrequest_b, grant_onehot_b;
    logic          out_wrequest_b, out_wlast_b, busy_b;
    logic [W-1:0]  out_wdata_b;

    int total = 0;
    int bad   = 0;

    logic [W:0] q_a [$];
    logic [W:0] q_b [$];
    logic [W:0] exp_a;
    logic [W:0] exp_b;
    bit mon_a = 1'b0;
    bit mon_b = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign in_rdata[W*gi +: W] = lane_data[gi];
    end

    munoc_rr_merge_arbiter #(.NUM_INPUT(N), .BW_DATA(W), .ORDERED(0)) dut_a (
        .clk(clk), .rst(rst), .init(init),
        .in_rready(in_rready), .in_rrequest(in_rrequest_a),
        .in_rdata(in_rdata), .in_rlast(in_rlast),
        .out_wready(out_wready), .out_wrequest(out_wrequest_a),
        .out_wdata(out_wdata_a), .out_wlast(out_wlast_a),
        .grant_onehot(grant_onehot_a), .busy(busy_a)
    );

    munoc_rr_merge_arbiter #(.NUM_INPUT(N), .BW_DATA(W), .ORDERED(1)) dut_b (
        .clk(clk), .rst(rst), .init(init),
        .in_rready(in_rready), .in_rrequest(in_rrequest_b),
        .in_rdata(in_rdata), .in_rlast(in_rlast),
        .out_wready(out_wready), .out_wrequest(out_wrequest_b),
        .out_wdata(out_wdata_b), .out_wlast(out_wlast_b),
        .grant_onehot(grant_onehot_b), .busy(busy_b)
    );

    // Scoreboard consumer for the work-conserving instance.
    always @(negedge clk) begin
        if (mon_a && out_wrequest_a) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL beat_a: got unexpected beat data=%h last=%b, required no beat", out_wdata_a, out_wlast_a);
            end else begin
                exp_a = q_a.pop_front();
                if ({out_wlast_a, out_wdata_a} !== exp_a) begin
                    bad++;
                    $display("FAIL beat_a: got last=%b data=%h, required last=%b data=%h", out_wlast_a, out_wdata_a, exp_a[W], exp_a[W-1:0]);
                end
            end
            total++;
            if (in_rrequest_a !== grant_onehot_a) begin
                bad++;
                $display("FAIL pop_a: got in_rrequest=%b, required %b", in_rrequest_a, grant_onehot_a);
            end
        end
    end

    // Scoreboard consumer for the ordered instance.
    always @(negedge clk) begin
        if (mon_b && out_wrequest_b) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL beat_b: got unexpected beat data=%h last=%b, required no beat", out_wdata_b, out_wlast_b);
            end else begin
                exp_b = q_b.pop_front();
                if ({out_wlast_b, out_wdata_b} !== exp_b) begin
                    bad++;
                    $display("FAIL beat_b: got last=%b data=%h, required last=%b data=%h", out_wlast_b, out_wdata_b, exp_b[W], exp_b[W-1:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; init = 1'b0; out_wready = 1'b1;
        in_rready = 4'b1111; in_rlast = 4'b1111;
        for (int i = 0; i < N; i++) lane_data[i] = 32'hA0 + i;
        repeat (2) begin
            tick();
            total++;
            if ({out_wrequest_a, in_rrequest_a, grant_onehot_a, out_wdata_a, out_wlast_a, busy_a} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got wreq=%b rreq=%b grant=%b data=%h last=%b busy=%b, required all 0",
                         out_wrequest_a, in_rrequest_a, grant_onehot_a, out_wdata_a, out_wlast_a, busy_a);
            end
        end
        rst = 1'b0;
        mon_a = 1'b1;
        q_a.push_back({1'b1, 32'hA0});
        #1;
        total++;
        if (grant_onehot_a !== 4'b0001) begin bad++; $display("FAIL reset_grant: got %b, required 0001", grant_onehot_a); end
        total++;
        if (out_wdata_a !== 32'hA0) begin bad++; $display("FAIL reset_data: got %h, required 000000a0", out_wdata_a); end
        total++;
        if (in_rrequest_a !== 4'b0001) begin bad++; $display("FAIL reset_pop: got %b, required 0001", in_rrequest_a); end
        tick();
        in_rready = 4'b0000;
    endtask

    task automatic test_fair_rotation;
        for (int i = 0; i < N; i++) lane_data[i] = i;
        in_rlast = 4'b1111;
        in_rready = 4'b1111;
        init = 1'b1;
        #1;
        total++;
        if (out_wrequest_a !== 1'b0) begin bad++; $display("FAIL init_no_xfer: got wreq=%b, required 0", out_wrequest_a); end
        tick();
        init = 1'b0;
        for (int k = 0; k < 6; k++) q_a.push_back({1'b1, 32'(k % 4)});
        for (int k = 0; k < 6; k++) begin
            #1;
            total++;
            if (grant_onehot_a !== 4'(1 << (k % 4))) begin
                bad++;
                $display("FAIL rotation_grant[%0d]: got %b, required %b", k, grant_onehot_a, 4'(1 << (k % 4)));
            end
            total++;
            if (busy_a !== 1'b0) begin bad++; $display("FAIL rotation_busy[%0d]: got %b, required 0", k, busy_a); end
            tick();
        end
        in_rready = 4'b0000;
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL rotation_drain: got %0d beats left, required 0", q_a.size()); end
    endtask

    task automatic test_packet_lock_stall;
        out_wready = 1'b1;
        lane_data[1] = 32'h0A1; in_rlast = 4'b0000; in_rready = 4'b0010;
        q_a.push_back({1'b0, 32'h0A1});
        #1;
        total++;
        if (grant_onehot_a !== 4'b0010 || busy_a !== 1'b0) begin
            bad++; $display("FAIL lock_first: got grant=%b busy=%b, required 0010 0", grant_onehot_a, busy_a);
        end
        tick();
        lane_data[1] = 32'h0A2; lane_data[0] = 32'h0B0; in_rlast = 4'b0001; in_rready = 4'b0011;
        q_a.push_back({1'b0, 32'h0A2});
        #1;
        total++;
        if (grant_onehot_a !== 4'b0010 || busy_a !== 1'b1) begin
            bad++; $display("FAIL lock_hold: got grant=%b busy=%b, required 0010 1", grant_onehot_a, busy_a);
        end
        tick();
        lane_data[1] = 32'h0A3; in_rlast = 4'b0011; out_wready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #1;
            total++;
            if (out_wrequest_a !== 1'b0 || in_rrequest_a !== 4'b0000 || busy_a !== 1'b1) begin
                bad++; $display("FAIL stall[%0d]: got wreq=%b rreq=%b busy=%b, required 0 0000 1", s, out_wrequest_a, in_rrequest_a, busy_a);
            end
            tick();
        end
        out_wready = 1'b1;
        q_a.push_back({1'b1, 32'h0A3});
        #1;
        total++;
        if (busy_a !== 1'b1 || out_wlast_a !== 1'b1 || grant_onehot_a !== 4'b0010) begin
            bad++; $display("FAIL lock_last: got busy=%b last=%b grant=%b, required 1 1 0010", busy_a, out_wlast_a, grant_onehot_a);
        end
        tick();
        in_rready = 4'b0001;
        q_a.push_back({1'b1, 32'h0B0});
        #1;
        total++;
        if (grant_onehot_a !== 4'b0001 || busy_a !== 1'b0) begin
            bad++; $display("FAIL lock_followon: got grant=%b busy=%b, required 0001 0", grant_onehot_a, busy_a);
        end
        tick();
        in_rready = 4'b0000;
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL lock_drain: got %0d beats left, required 0", q_a.size()); end
    endtask

    task automatic test_wrap_around;
        in_rlast = 4'b1111;
        lane_data[2] = 32'h02C; in_rready = 4'b0100;
        q_a.push_back({1'b1, 32'h02C});
        tick();
        lane_data[1] = 32'h01D; in_rready = 4'b0010;
        q_a.push_back({1'b1, 32'h01D});
        #1;
        total++;
        if (grant_onehot_a !== 4'b0010) begin bad++; $display("FAIL wrap_grant: got %b, required 0010", grant_onehot_a); end
        tick();
        lane_data[1] = 32'h01E; lane_data[2] = 32'h02E; in_rready = 4'b0110;
        q_a.push_back({1'b1, 32'h02E});
        #1;
        total++;
        if (grant_onehot_a !== 4'b0100) begin bad++; $display("FAIL wrap_ptr: got %b, required 0100", grant_onehot_a); end
        tick();
        in_rready = 4'b0000;
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL wrap_drain: got %0d beats left, required 0", q_a.size()); end
    endtask

    task automatic test_init_mid_packet;
        lane_data[2] = 32'h201; in_rlast = 4'b0000; in_rready = 4'b0100;
        q_a.push_back({1'b0, 32'h201});
        #1;
        total++;
        if (busy_a !== 1'b0) begin bad++; $display("FAIL init_pre_busy: got %b, required 0", busy_a); end
        tick();
        init = 1'b1; lane_data[0] = 32'h00F; lane_data[2] = 32'h202;
        in_rlast = 4'b0001; in_rready = 4'b0101;
        #1;
        total++;
        if (out_wrequest_a !== 1'b0 || in_rrequest_a !== 4'b0000 || busy_a !== 1'b1) begin
            bad++; $display("FAIL init_cycle: got wreq=%b rreq=%b busy=%b, required 0 0000 1", out_wrequest_a, in_rrequest_a, busy_a);
        end
        tick();
        init = 1'b0;
        q_a.push_back({1'b1, 32'h00F});
        #1;
        total++;
        if (busy_a !== 1'b0 || grant_onehot_a !== 4'b0001) begin
            bad++; $display("FAIL init_after: got busy=%b grant=%b, required 0 0001", busy_a, grant_onehot_a);
        end
        tick();
        in_rready = 4'b0000;
        total++;
        if (q_a.size() != 0) begin bad++; $display("FAIL init_drain: got %0d beats left, required 0", q_a.size()); end
    endtask

    task automatic test_ordered;
        mon_a = 1'b0;
        mon_b = 1'b1;
        init = 1'b1; in_rready = 4'b0000;
        tick();
        init = 1'b0;
        in_rlast = 4'b1111; lane_data[2] = 32'h02A; in_rready = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (out_wrequest_b !== 1'b0 || grant_onehot_b !== 4'b0000) begin
                bad++; $display("FAIL ordered_wait[%0d]: got wreq=%b grant=%b, required 0 0000", c, out_wrequest_b, grant_onehot_b);
            end
            tick();
        end
        lane_data[0] = 32'h00A; in_rready = 4'b0101;
        q_b.push_back({1'b1, 32'h00A});
        #1;
        total++;
        if (grant_onehot_b !== 4'b0001) begin bad++; $display("FAIL ordered_lane0: got %b, required 0001", grant_onehot_b); end
        tick();
        in_rready = 4'b0100;
        #1;
        total++;
        if (out_wrequest_b !== 1'b0) begin bad++; $display("FAIL ordered_skip2: got wreq=%b, required 0", out_wrequest_b); end
        tick();
        lane_data[1] = 32'h01A; in_rready = 4'b0110;
        q_b.push_back({1'b1, 32'h01A});
        #1;
        total++;
        if (grant_onehot_b !== 4'b0010) begin bad++; $display("FAIL ordered_lane1: got %b, required 0010", grant_onehot_b); end
        tick();
        in_rready = 4'b0100;
        q_b.push_back({1'b1, 32'h02A});
        #1;
        total++;
        if (grant_onehot_b !== 4'b0100) begin bad++; $display("FAIL ordered_lane2: got %b, required 0100", grant_onehot_b); end
        tick();
        in_rready = 4'b0000;
        total++;
        if (q_b.size() != 0) begin bad++; $display("FAIL ordered_drain: got %0d beats left, required 0", q_b.size()); end
        mon_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fair_rotation();
        test_packet_lock_stall();
        test_wrap_around();
        test_init_mid_packet();
        test_ordered();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
